// File: rtl/dff_r_bank.sv
`default_nettype none
// ============================================================================
// Module   : dff_r_bank
// Function : rising-edge D flop bank, async active-high reset to RESET_VAL.
//            `define DFF_R_BANK_CHECKS_EN compiles in simulation-only checks.
// Revision : 1.0
// ============================================================================
module dff_r_bank #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d
);

  // Bits are independent flops; one vector register keeps the netlist flat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

`ifdef DFF_R_BANK_CHECKS_EN
  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $fatal(1, "dff_r_bank: WIDTH=%0d outside 1..64", WIDTH);
  end

  always @(posedge clk) begin
    if (!reset && $isunknown(d)) begin
      $error("dff_r_bank: d=%b unknown at clk edge", d);
    end
  end

  always @(reset) begin
    if ($time > 0 && $isunknown(reset)) begin
      $error("dff_r_bank: reset is X/Z");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_r_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_r_bank
// Function : directed self-checking bench for dff_r_bank (1-bit, 8-bit, LFSR).
// Revision : 1.0
// ============================================================================
module tb_dff_r_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [8:0] lq;
  logic [8:0] ld;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dff_r_bank u_b1 (.q(q1), .clk(clk), .reset(reset), .d(d1));

  dff_r_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) u_b8 (
    .q(q8), .clk(clk), .reset(reset), .d(d8)
  );

  // x^9 + x^4 + 1: d0 = q3 ^ q8, d_i = q_{i-1}
  assign ld = {lq[7:0], lq[3] ^ lq[8]};

  for (genvar i = 0; i < 9; i++) begin : g_lfsr
    dff_r_bank u_cell (.q(lq[i]), .clk(clk), .reset(reset), .d(ld[i]));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    logic [8:0] model;
    int         zero_seen;
    int         early_ret;
    int         model_bad;

    reset = 1'b1;
    d1    = 1'b0;
    d8    = 8'h00;
    #1;
    check("rst_q1_t0", q1, 1'b1);
    check("rst_q8_t0", q8, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_q1_held", q1, 1'b1);
      check("rst_q8_held", q8, 8'hA5);
    end

    // Release and capture
    @(negedge clk);
    reset = 1'b0;
    d8    = 8'h3C;
    #1;
    check("release_no_edge", q1, 1'b1);
    @(posedge clk); #1;
    check("cap_q1_0", q1, 1'b0);
    check("cap_q8_3c", q8, 8'h3C);
    @(negedge clk);
    d8 = 8'hC3;
    #1;
    check("hold_between_edges", q8, 8'h3C);
    @(posedge clk); #1;
    check("cap_q8_c3", q8, 8'hC3);

    // Async assert mid-cycle
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_q1", q1, 1'b1);
    check("async_q8", q8, 8'hA5);

    @(negedge clk);
    reset = 1'b0;
    d1    = 1'b0;
    d8    = 8'h5A;
    @(posedge clk); #1;
    check("resume_q1", q1, 1'b0);
    check("resume_q8", q8, 8'h5A);

    // Reset rising on the same edge that samples d=0
    @(negedge clk);
    d8 = 8'h00;
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("simul_q1", q1, 1'b1);
    check("simul_q8", q8, 8'hA5);

    // Reset held across an edge with d changing
    @(negedge clk);
    d1 = 1'b0;
    d8 = 8'hFF;
    @(posedge clk); #1;
    check("held_ignores_d", q8, 8'hA5);
    check("held_ignores_d1", q1, 1'b1);

    @(negedge clk);
    reset = 1'b0;
    d8    = 8'h81;
    d1    = 1'b0;
    @(posedge clk); #1;
    check("first_edge_q8", q8, 8'h81);
    check("first_edge_q1", q1, 1'b0);

    // LFSR integration
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("lfsr_rst", lq, 9'h1FF);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("lfsr_release", lq, 9'h1FF);
    @(posedge clk); #1;
    check("lfsr_edge1", lq, 9'h1FE);

    model     = 9'h1FE;
    zero_seen = 0;
    early_ret = 0;
    model_bad = 0;
    for (int e = 2; e <= 511; e++) begin
      @(posedge clk); #1;
      model = {model[7:0], model[3] ^ model[8]};
      if (lq !== model) model_bad++;
      if (lq == 9'h000) zero_seen++;
      if (lq == 9'h1FF && e < 511) early_ret++;
    end
    check("lfsr_model", model_bad, 0);
    check("lfsr_period_511", lq, 9'h1FF);
    check("lfsr_no_zero", zero_seen, 0);
    check("lfsr_no_early_return", early_ret, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
